// File: rtl/pe_ctrl_pkg.sv
// Shared definitions for the PE start/enable control slice.
package pe_ctrl_pkg;

    localparam int unsigned NUM_PE_DEF = 4;
    localparam int unsigned CNT_W_DEF  = 16;
    localparam int unsigned STG_W_DEF  = 4;

    typedef enum logic [2:0] {
        IDLE,
        RAMP_UP,
        RUN,
        RAMP_DOWN,
        DONE
    } pe_seq_state_e;

endpackage

// File: rtl/pe_mask_next.sv
// Finds the lowest set mask bit above idx (or at/above idx when incl is set).
module pe_mask_next #(
    parameter int unsigned NUM_PE = 4,
    parameter int unsigned IW     = 2
) (
    input  logic [NUM_PE-1:0] mask,
    input  logic [IW-1:0]     idx,
    input  logic              incl,
    output logic [IW-1:0]     next_idx,
    output logic              none_left
);

    // Descending scan so the lowest qualifying index is written last.
    always_comb begin
        next_idx  = '0;
        none_left = 1'b1;
        for (int i = int'(NUM_PE) - 1; i >= 0; i--) begin
            if (mask[i] && ((incl && (i >= int'(idx))) || (i > int'(idx)))) begin
                next_idx  = IW'(i);
                none_left = 1'b0;
            end
        end
    end

endmodule

// File: rtl/pe_start_sequencer.sv
// Staggered ap_start ramp-up / hold / ramp-down sequencer for a group of PE tiles,
// with abort and a one-cycle done/aborted completion pulse.
module pe_start_sequencer
    import pe_ctrl_pkg::*;
#(
    parameter int unsigned NUM_PE = NUM_PE_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned STG_W  = STG_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [NUM_PE-1:0] cfg_pe_mask,
    input  logic [CNT_W-1:0]  cfg_run_len,
    input  logic [STG_W-1:0]  cfg_stagger,
    input  logic              abort,
    output logic [NUM_PE-1:0] ap_start,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    localparam int unsigned IW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int unsigned MW = $clog2(NUM_PE + 1);
    localparam int unsigned CW = (CNT_W > STG_W) ? CNT_W : STG_W;

    function automatic logic [MW-1:0] popcount(input logic [NUM_PE-1:0] v);
        popcount = '0;
        for (int i = 0; i < int'(NUM_PE); i++) begin
            popcount = popcount + MW'(v[i]);
        end
    endfunction

    pe_seq_state_e     state_q, state_d;
    logic [NUM_PE-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [STG_W-1:0]  stg_q, stg_d;
    logic [MW-1:0]     m_q, m_d;
    logic [MW-1:0]     left_q, left_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     rise_q, rise_d;
    logic [IW-1:0]     fall_q, fall_d;
    logic [NUM_PE-1:0] ap_start_d;
    logic              cfg_ready_d, busy_d, done_d, aborted_d;

    logic [NUM_PE-1:0] q_mask;
    logic [IW-1:0]     q_idx;
    logic              q_incl;
    logic [IW-1:0]     q_next;
    logic              q_none;

    pe_mask_next #(
        .NUM_PE (NUM_PE),
        .IW     (IW)
    ) u_mask_next (
        .mask      (q_mask),
        .idx       (q_idx),
        .incl      (q_incl),
        .next_idx  (q_next),
        .none_left (q_none)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            len_q     <= '0;
            stg_q     <= '0;
            m_q       <= '0;
            left_q    <= '0;
            cnt_q     <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            ap_start  <= '0;
            cfg_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            len_q     <= len_d;
            stg_q     <= stg_d;
            m_q       <= m_d;
            left_q    <= left_d;
            cnt_q     <= cnt_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            ap_start  <= ap_start_d;
            cfg_ready <= cfg_ready_d;
            busy      <= busy_d;
            done      <= done_d;
            aborted   <= aborted_d;
        end
    end

    // Rises walk rise_q with an S+1 spacing; after L hold cycles falls walk fall_q the same way.
    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        len_d      = len_q;
        stg_d      = stg_q;
        m_d        = m_q;
        left_d     = left_q;
        cnt_d      = cnt_q;
        rise_d     = rise_q;
        fall_d     = fall_q;
        ap_start_d = ap_start;
        done_d     = 1'b0;
        aborted_d  = 1'b0;
        q_mask     = mask_q;
        q_idx      = fall_q;
        q_incl     = 1'b0;

        case (state_q)
            IDLE: begin
                q_mask = cfg_pe_mask;
                q_idx  = '0;
                q_incl = 1'b1;
                if (cfg_valid) begin
                    mask_d = cfg_pe_mask;
                    len_d  = cfg_run_len;
                    stg_d  = cfg_stagger;
                    m_d    = popcount(cfg_pe_mask);
                    if (q_none || (cfg_run_len == '0)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        ap_start_d[q_next] = 1'b1;
                        rise_d             = q_next;
                        fall_d             = q_next;
                        if (m_d == MW'(1)) begin
                            state_d = RUN;
                            cnt_d   = CW'(cfg_run_len - CNT_W'(1));
                        end else begin
                            state_d = RAMP_UP;
                            cnt_d   = CW'(cfg_stagger);
                            left_d  = m_d - MW'(1);
                        end
                    end
                end
            end
            RAMP_UP: begin
                q_idx = rise_q;
                if (abort) begin
                    ap_start_d = '0;
                    state_d    = DONE;
                    done_d     = 1'b1;
                    aborted_d  = 1'b1;
                end else if (cnt_q == '0) begin
                    ap_start_d[q_next] = 1'b1;
                    rise_d             = q_next;
                    if (left_q == MW'(1)) begin
                        state_d = RUN;
                        cnt_d   = CW'(len_q - CNT_W'(1));
                    end else begin
                        cnt_d  = CW'(stg_q);
                        left_d = left_q - MW'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RUN: begin
                if (abort) begin
                    ap_start_d = '0;
                    state_d    = DONE;
                    done_d     = 1'b1;
                    aborted_d  = 1'b1;
                end else if (cnt_q == '0) begin
                    ap_start_d[fall_q] = 1'b0;
                    if (m_q == MW'(1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RAMP_DOWN;
                        cnt_d   = CW'(stg_q);
                        left_d  = m_q - MW'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RAMP_DOWN: begin
                if (abort) begin
                    ap_start_d = '0;
                    state_d    = DONE;
                    done_d     = 1'b1;
                    aborted_d  = 1'b1;
                end else if (cnt_q == '0) begin
                    ap_start_d[q_next] = 1'b0;
                    fall_d             = q_next;
                    if (left_q == MW'(1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d  = CW'(stg_q);
                        left_d = left_q - MW'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d    = IDLE;
                ap_start_d = '0;
            end
        endcase

        cfg_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

endmodule

// File: doc/pe_start_sequencer.md
PE_START_SEQUENCER -- requirements
Module: pe_start_sequencer

Interface
REQ-001 SHALL have parameter NUM_PE, default 4: number of PE tiles driven (ap_start fan-out).
REQ-002 SHALL have parameter CNT_W, default 16: run-length field width.
REQ-003 SHALL have parameter STG_W, default 4: stagger field width.
REQ-004 SHALL have port clk, input, 1: clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port cfg_valid, input, 1: launch request.
REQ-007 SHALL have port cfg_ready, output, 1: high only in IDLE.
REQ-008 SHALL have port cfg_pe_mask, input, NUM_PE: tiles to run; bit k drives ap_start[k].
REQ-009 SHALL have port cfg_run_len, input, CNT_W: L, run cycles with all masked tiles started.
REQ-010 SHALL have port cfg_stagger, input, STG_W: S; spacing between successive tile starts is S+1 cycles.
REQ-011 SHALL have port abort, input, 1: terminate the active run.
REQ-012 SHALL have port ap_start, output, NUM_PE: registered per-tile start/enable.
REQ-013 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-014 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-015 SHALL have port aborted, output, 1: valid with done; 1 = run was aborted.

Function
REQ-016 SHALL implement states IDLE, RAMP_UP, RUN, RAMP_DOWN, DONE.
REQ-017 SHALL accept the config on the cycle cfg_valid && cfg_ready (cycle 0) and latch mask, L, S; inputs are ignored afterwards until IDLE.
REQ-018 SHALL, with M = popcount(mask) and masked tiles ordered by ascending index k = 0..M-1, raise ap_start of the k-th masked tile at cycle 1 + k*(S+1).
REQ-019 SHALL hold every masked tile high for exactly H = (M-1)*(S+1) + L consecutive cycles, so tiles fall in the same order and spacing as they rose.
REQ-020 SHALL keep ap_start of unmasked tiles at 0 throughout.
REQ-021 SHALL enter DONE the cycle after the last masked tile falls: done=1, aborted=0 for one cycle; IDLE the following cycle.
REQ-022 SHALL, when mask==0 or L==0, assert no ap_start and enter DONE at cycle 1 (done=1, aborted=0).
REQ-023 SHALL, when abort is sampled high in RAMP_UP, RUN or RAMP_DOWN, drive all ap_start to 0 and enter DONE with done=1, aborted=1 on the next cycle.
REQ-024 SHALL ignore abort in IDLE and DONE; abort with cfg_valid in IDLE accepts the config.
REQ-025 SHALL size internal counters so that maximum L, S and NUM_PE never wrap; L = 2^CNT_W-1 runs to completion.
REQ-026 SHALL keep cfg_ready low in DONE; the earliest next accept is the IDLE cycle after DONE.

Reset
REQ-027 SHALL, while reset is high, force state IDLE, ap_start=0, done=0, aborted=0, busy=0, and clear all counters and latched config.
REQ-028 SHALL, on reset mid-run, drop all ap_start on the next edge with no done pulse.

Structure
REQ-029 SHALL place the state enum and default NUM_PE/CNT_W/STG_W constants in shared package pe_ctrl_pkg.
REQ-030 SHALL use one combinational sub-module, pe_mask_next, that returns the next set mask index above a given index plus a none-left flag.

Verification
REQ-031 SHALL cover mask=4'b1011, S=1, L=3: ap_start[0] high cycles 1-7, [1] 3-9, [3] 5-11, [2] never; done at 12; cfg_ready at 13.
REQ-032 SHALL cover mask=4'b0000, L=5: no ap_start; done=1, aborted=0 at cycle 1; busy high only at cycle 1.
REQ-033 SHALL cover mask=4'b1111, S=0, L=10 with abort at cycle 6: all ap_start 0 at cycle 7; done=1, aborted=1 at 7; IDLE at 8.
REQ-034 SHALL cover reset at cycle 4 of the REQ-031 run: ap_start=0 at cycle 5, no done pulse, cfg_ready=1 after reset release.
REQ-035 SHALL cover mask=4'b0100, S=15, L=1: ap_start[2] high cycle 1 only; done at 2.
REQ-036 SHALL cover cfg_valid held high continuously: back-to-back runs with exactly one IDLE cycle between DONE and the next accept.
